// File: rtl/delay_pkg.sv
// Shared types for the programmable delay-line sequencer.
// Sequencer states, default depth and the delay-value type.
package delay_pkg;

    localparam int LGDLY_DEF = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_APPLY = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

    typedef logic [LGDLY_DEF-1:0] delay_t;

endpackage

// File: rtl/delay_ctrl.sv
// Delay-change sequencer: applies a new delay, waits for the line to refill.
// Option DELAY_CTRL_SAME_SKIP_EN: unchanged-delay requests in RUN are absorbed.
module delay_ctrl
    import delay_pkg::*;
#(
    parameter int               LGDLY      = LGDLY_DEF,
    parameter logic [LGDLY-1:0] INIT_DELAY = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ce,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [LGDLY-1:0] i_req_delay,
    output logic             o_dly_reset,
    output logic [LGDLY-1:0] o_dly_delay,
    output logic             o_dly_ce,
    output logic             o_valid,
    output logic             o_busy
);

    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_APPLY = ST_APPLY;
    localparam logic [1:0] S_FILL  = ST_FILL;

    localparam logic [LGDLY:0] CNT_ONE = {{LGDLY{1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [LGDLY-1:0] r_delay;
    logic [LGDLY-1:0] w_delay_nx;
    logic [LGDLY:0]   r_cnt;
    logic [LGDLY:0]   w_cnt_nx;
    logic [LGDLY:0]   w_cnt_inc;
    logic             r_dly_reset;
    logic             r_valid;
    logic             w_accept;
    logic             w_skip;
    logic             w_done;

    assign o_req_ready = (r_state != S_APPLY);
    assign o_busy      = (r_state != S_RUN);
    assign o_dly_ce    = i_ce;
    assign o_dly_reset = r_dly_reset;
    assign o_dly_delay = r_delay;
    assign o_valid     = r_valid;

    assign w_accept = i_req_valid && o_req_ready;

`ifdef DELAY_CTRL_SAME_SKIP_EN
    assign w_skip = (r_state == S_RUN) && (i_req_delay == r_delay);
`else
    assign w_skip = 1'b0;
`endif

    // Fill counter saturates so a stalled refill can never wrap past the target
    assign w_cnt_inc = (i_ce && (r_cnt != '1)) ? (r_cnt + CNT_ONE) : r_cnt;
    assign w_done    = (w_cnt_inc >= {1'b0, r_delay});

    always_comb begin
        w_state_nx = r_state;
        w_delay_nx = r_delay;
        w_cnt_nx   = r_cnt;
        if (w_accept && !w_skip) begin
            w_state_nx = S_APPLY;
            w_delay_nx = i_req_delay;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                S_APPLY: begin
                    w_cnt_nx   = w_cnt_inc;
                    w_state_nx = (r_delay == '0) ? S_RUN : S_FILL;
                end
                S_FILL: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_done) begin
                        w_state_nx = S_RUN;
                    end
                end
                default: begin
                    w_state_nx = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_APPLY;
            r_delay     <= INIT_DELAY;
            r_cnt       <= '0;
            r_dly_reset <= 1'b1;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_delay     <= w_delay_nx;
            r_cnt       <= w_cnt_nx;
            r_dly_reset <= (w_state_nx == S_APPLY);
            // A strobe taken in RUN used the old, fully filled delay
            r_valid     <= i_ce && (r_state == S_RUN);
        end
    end

endmodule
